// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types for the execute-stage forwarding / hazard controller.
//   fwd_sel_t  : 2-bit select driven into each operand mux3
//                (00 register file, 01 W-stage result, 10 M-stage ALU result).
//   e_tag_t    : register tag held for the instruction in execute.
//   mw_tag_t   : register tag held for the instructions in memory and writeback.
package hazard_pkg;

  // Register-index width carried in the tag structs.
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             load;
  } e_tag_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } mw_tag_t;

  // A bubble carries no destination, so it can never match a consumer.
  localparam e_tag_t E_BUBBLE = '0;

endpackage

// File: rtl/fwd_select.sv
// fwd_select
//   Combinational priority compare of one execute-stage source register
//   against the M and W destination tags.
//   Ports:
//     src_e  in  source register of the instruction in execute
//     m_tag  in  destination tag of the instruction in memory
//     w_tag  in  destination tag of the instruction in writeback
//     sel    out operand mux3 select (never 2'b11)
module fwd_select
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] src_e,
  input  mw_tag_t          m_tag,
  input  mw_tag_t          w_tag,
  output fwd_sel_t         sel
);

  always_comb begin
    sel = FWD_RF;
    // x0 is hard-wired zero, so it never takes a forwarded value.
    if (src_e != '0) begin
      // M is the younger producer and wins when both stages match.
      if (m_tag.reg_write && (m_tag.rd == src_e)) begin
        sel = FWD_MEM;
      end else if (w_tag.reg_write && (w_tag.rd == src_e)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl
//   Hazard and forwarding controller for the five-stage core. Tracks
//   register tags through E, M and W and produces the operand-mux selects
//   plus fetch/decode stall and flush controls.
//   Ports:
//     clk, reset               clock, asynchronous active-high reset
//     rs1_d, rs2_d, rd_d       decode-stage register fields
//     reg_write_d, load_d      decode-stage write-back / load flags
//     pc_src_e                 branch/jump taken in execute
//     forward_a_e, forward_b_e operand mux3 selects
//     stall_f, stall_d         hold PC and F/D register
//     flush_d, flush_e         clear F/D and D/E registers
//   All outputs are combinational from the tag registers and decode inputs.
//   The tag structs are sized by hazard_pkg::REG_W; XLEN_REG must match it.
module forward_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN_REG = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [XLEN_REG-1:0] rs1_d,
  input  logic [XLEN_REG-1:0] rs2_d,
  input  logic [XLEN_REG-1:0] rd_d,
  input  logic                reg_write_d,
  input  logic                load_d,
  input  logic                pc_src_e,
  output logic [1:0]          forward_a_e,
  output logic [1:0]          forward_b_e,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e
);

  e_tag_t  e_q, e_d;
  mw_tag_t m_q, m_d;
  mw_tag_t w_q, w_d;

  logic     load_use;
  logic     lw_stall;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  fwd_select u_fwd_a (
    .src_e (e_q.rs1),
    .m_tag (m_q),
    .w_tag (w_q),
    .sel   (sel_a)
  );

  fwd_select u_fwd_b (
    .src_e (e_q.rs2),
    .m_tag (m_q),
    .w_tag (w_q),
    .sel   (sel_b)
  );

  always_comb begin
    load_use = e_q.load && (e_q.rd != '0) &&
               ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
    // A taken branch squashes the dependent anyway, so never hold the PC
    // against a redirect. Reset forces every control low even though the
    // tags are already cleared, because pc_src_e is an external input.
    lw_stall = load_use && !pc_src_e && !reset;
    flush_d  = pc_src_e && !reset;
    flush_e  = lw_stall || flush_d;
    stall_f  = lw_stall;
    stall_d  = lw_stall;

    forward_a_e = reset ? FWD_RF : sel_a;
    forward_b_e = reset ? FWD_RF : sel_b;

    e_d = flush_e ? E_BUBBLE : '{rs1:       rs1_d,
                                 rs2:       rs2_d,
                                 rd:        rd_d,
                                 reg_write: reg_write_d,
                                 load:      load_d};
    m_d = '{rd: e_q.rd, reg_write: e_q.reg_write};
    w_d = m_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= E_BUBBLE;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

endmodule

// File: tb/tb_forward_ctrl.sv
module tb_forward_ctrl;
  import hazard_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
  logic       reg_write_d = 1'b0, load_d = 1'b0, pc_src_e = 1'b0;
  logic [1:0] forward_a_e, forward_b_e;
  logic       stall_f, stall_d, flush_d, flush_e;

  forward_ctrl #(.XLEN_REG(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .rs1_d       (rs1_d),
    .rs2_d       (rs2_d),
    .rd_d        (rd_d),
    .reg_write_d (reg_write_d),
    .load_d      (load_d),
    .pc_src_e    (pc_src_e),
    .forward_a_e (forward_a_e),
    .forward_b_e (forward_b_e),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .flush_e     (flush_e)
  );

  always #5 clk = ~clk;

  // Reference model: the instructions currently in E, M, W (index = age).
  typedef struct {
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       sf;
    logic       sd;
    logic       fd;
    logic       fe;
  } exp_t;

  instr_t pipe[$];
  exp_t   sb[$];
  int     vectors = 0;
  int     miscompares = 0;

  function automatic instr_t bubble();
    instr_t b;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.rw = 1'b0; b.ld = 1'b0;
    return b;
  endfunction

  // Nearest older producer of src: one stage ahead -> M-stage result (2),
  // two stages ahead -> W-stage result (1), otherwise register file (0).
  function automatic int fwd_of(int src);
    if (src == 0) return 0;
    for (int d = 1; d <= 2; d++) begin
      if (pipe[d].rw && pipe[d].rd == src) return (d == 1) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    bit   hz;
    bit   stall;
    e = '0;
    if (reset) return e;
    hz = pipe[0].ld && pipe[0].rd != 0 &&
         (pipe[0].rd == int'(rs1_d) || pipe[0].rd == int'(rs2_d));
    stall = hz && !pc_src_e;
    e.fa = 2'(fwd_of(pipe[0].rs1));
    e.fb = 2'(fwd_of(pipe[0].rs2));
    e.sf = stall;
    e.sd = stall;
    e.fd = pc_src_e;
    e.fe = stall || pc_src_e;
    return e;
  endfunction

  task automatic model_clear();
    pipe.delete();
    for (int i = 0; i < 3; i++) pipe.push_back(bubble());
  endtask

  // Advance the model across one rising edge using the inputs held there.
  task automatic model_edge();
    exp_t   e;
    instr_t n;
    if (reset) begin
      model_clear();
    end else begin
      e = expect_now();
      if (e.fe) n = bubble();
      else begin
        n.rs1 = int'(rs1_d); n.rs2 = int'(rs2_d); n.rd = int'(rd_d);
        n.rw = reg_write_d; n.ld = load_d;
      end
      pipe.push_front(n);
      void'(pipe.pop_back());
    end
  endtask

  task automatic issue(input int r1, input int r2, input int rd, input bit rw,
                       input bit ld, input bit pc, input bit rst);
    @(posedge clk);
    #1;
    model_edge();
    reset       = rst;
    rs1_d       = r1[4:0];
    rs2_d       = r2[4:0];
    rd_d        = rd[4:0];
    reg_write_d = rw;
    load_d      = ld;
    pc_src_e    = pc;
    #1;
    sb.push_back(expect_now());
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    forever begin
      exp_t e;
      exp_t a;
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {forward_a_e, forward_b_e, stall_f, stall_d, flush_d, flush_e};
        vectors++;
        if (a !== e || forward_a_e == 2'b11 || forward_b_e == 2'b11) begin
          miscompares++;
          $display("FAIL outputs t=%0t: got fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b, expected fa=%b fb=%b sf=%b sd=%b fd=%b fe=%b",
                   $time, a.fa, a.fb, a.sf, a.sd, a.fd, a.fe,
                   e.fa, e.fb, e.sf, e.sd, e.fd, e.fe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    issue(0, 0, 0, 0, 0, 0, 1);
    issue(0, 0, 0, 0, 0, 1, 1);
    at_neg();
    chk("reset_flush_d", int'(flush_d), 0);

    // Distance-1 forward from M, then an unrelated instruction.
    issue(1, 2, 5, 1, 0, 0, 0);
    issue(5, 1, 6, 1, 0, 0, 0);
    issue(3, 4, 9, 1, 0, 0, 0);
    at_neg(); chk("dist1_fwd_a", int'(forward_a_e), 2);
    issue(10, 11, 0, 0, 0, 0, 0);
    at_neg(); chk("dist1_next_a", int'(forward_a_e), 0);

    // Distance-2 forward from W on operand B.
    issue(1, 1, 7, 1, 0, 0, 0);
    issue(2, 3, 10, 1, 0, 0, 0);
    issue(4, 7, 11, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("dist2_fwd_b", int'(forward_b_e), 1);

    // x7 written in both M and W: M wins.
    issue(1, 1, 7, 1, 0, 0, 0);
    issue(2, 2, 7, 1, 0, 0, 0);
    issue(3, 7, 12, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("priority_fwd_b", int'(forward_b_e), 2);

    // Load-use: one stall cycle, then forward from W.
    issue(1, 0, 8, 1, 1, 0, 0);
    issue(8, 2, 13, 1, 0, 0, 0);
    at_neg(); chk("lu_stall_f", int'(stall_f), 1); chk("lu_flush_e", int'(flush_e), 1);
    issue(8, 2, 13, 1, 0, 0, 0);
    at_neg(); chk("lu_stall_released", int'(stall_f), 0);
    issue(3, 3, 14, 1, 0, 0, 0);
    at_neg(); chk("lu_fwd_a_wb", int'(forward_a_e), 1);

    // x0 is never a source.
    issue(1, 1, 0, 1, 0, 0, 0);
    issue(0, 0, 15, 1, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0);
    at_neg(); chk("x0_fwd_a", int'(forward_a_e), 0);
    issue(1, 1, 0, 1, 1, 0, 0);
    issue(0, 0, 3, 1, 0, 0, 0);
    at_neg(); chk("x0_no_stall", int'(stall_f), 0);

    // Taken branch with a load-use hazard.
    issue(1, 0, 8, 1, 1, 0, 0);
    issue(8, 8, 9, 1, 0, 1, 0);
    at_neg();
    chk("br_flush_d", int'(flush_d), 1);
    chk("br_flush_e", int'(flush_e), 1);
    chk("br_stall_f", int'(stall_f), 0);
    issue(0, 0, 0, 0, 0, 0, 0);
    issue(9, 8, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a stall.
    issue(1, 0, 8, 1, 1, 0, 0);
    issue(8, 0, 9, 1, 0, 0, 0);
    at_neg(); chk("mid_stall_before", int'(stall_f), 1);
    reset = 1'b1;
    #1;
    chk("rst_stall_f", int'(stall_f), 0);
    chk("rst_flush_e", int'(flush_e), 0);
    pc_src_e = 1'b1;
    #1;
    chk("rst_flush_d", int'(flush_d), 0);
    issue(1, 2, 5, 1, 0, 1, 1);
    issue(5, 5, 16, 1, 0, 0, 0);
    at_neg(); chk("post_rst_fwd_a", int'(forward_a_e), 0);
    issue(16, 5, 0, 0, 0, 0, 0);
    at_neg(); chk("post_rst_fwd_b", int'(forward_b_e), 0);

    // Randomized traffic over a small register range to provoke hazards.
    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'b0);
    end

    issue(0, 0, 0, 0, 0, 0, 0);
    at_neg();
    chk("scoreboard_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
